scan_line_packer: RTL and testbench
===================================

SCAN_LINE_PACKER -- requirements
Module: scan_line_packer

Interface
REQ-001 SHALL have parameter LINE_LEN, default 64, meaning samples per scan line (1..255).
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO depth in bytes (power of two, >=4).
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the line-start marker byte.
REQ-004 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port nCLR  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port LINE_START  input  1  single-cycle request to capture one line.
REQ-007 SHALL have port D  input  8  sample from the upstream 8-bit data counter.
REQ-008 SHALL have port nEN  output  1  active-low source enable; low means D is consumed this cycle.
REQ-009 SHALL have port OUT_DATA  output  8  FIFO head byte.
REQ-010 SHALL have port OUT_VALID  output  1  OUT_DATA holds a valid byte.
REQ-011 SHALL have port OUT_READY  input  1  downstream accepts OUT_DATA.
REQ-012 SHALL have port BUSY  output  1  high while state is not IDLE.
REQ-013 SHALL have port LINE_CNT  output  8  count of completed lines, wraps 255->0.

Function
REQ-014 SHALL implement states IDLE, SYNC, HDR, CAPTURE (plus CSUM, see Configuration).
REQ-015 IDLE -> SYNC on LINE_START=1; LINE_START SHALL be ignored in every other state.
REQ-016 SYNC: push SYNC_BYTE when FIFO not full, then -> HDR; hold in SYNC while full.
REQ-017 HDR: push current LINE_CNT when not full, then -> CAPTURE; hold while full.
REQ-018 CAPTURE: when FIFO not full, nEN=0 and D pushed the same cycle; sample counter increments.
REQ-019 nEN SHALL be 1 in every state except CAPTURE-and-not-full; source never advances without a push.
REQ-020 After the LINE_LEN-th sample push -> IDLE (or CSUM if enabled); LINE_CNT increments on the final push of the line.
REQ-021 "Full" = occupancy==DEPTH, evaluated before the cycle's pop; a push is blocked when full even if a pop occurs that cycle.
REQ-022 Pop occurs when OUT_VALID=1 and OUT_READY=1; OUT_VALID = occupancy!=0.
REQ-023 First-word-fall-through: a byte pushed in cycle N SHALL be on OUT_DATA with OUT_VALID=1 in cycle N+1 if FIFO was empty.
REQ-024 OUT_DATA SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-025 Simultaneous push and pop (not full) SHALL leave occupancy unchanged; bytes exit in push order.
REQ-026 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy counter width log2(DEPTH)+1.
REQ-027 FIFO drains independently of state; a new line may start while prior bytes remain queued.

Reset
REQ-028 nCLR=0 at a rising edge SHALL set state IDLE, occupancy 0, pointers 0, sample counter 0, LINE_CNT 0.
REQ-029 During and after reset: nEN=1, OUT_VALID=0, BUSY=0, OUT_DATA=8'h00.
REQ-030 Reset mid-line SHALL discard queued bytes; no partial line completes; LINE_CNT not incremented.

Configuration
REQ-031 With macro SCAN_LINE_PACKER_CHECKSUM_EN defined, after the last sample -> CSUM, push 8-bit sum (mod 256) of the line's LINE_LEN samples when not full, then -> IDLE; LINE_CNT increments on this push.
REQ-032 Without SCAN_LINE_PACKER_CHECKSUM_EN, CSUM state and sum register SHALL not exist; line = SYNC, header, LINE_LEN samples.

Verification
REQ-033 LINE_LEN=4, OUT_READY=1, D counting 0,1,2,3 -> OUT stream A5,00,00,01,02,03; LINE_CNT=1; nEN low exactly 4 cycles.
REQ-034 DEPTH=4, LINE_LEN=8, OUT_READY=0 -> 4 bytes queued, nEN=1, BUSY=1, state held; release OUT_READY -> all 10 bytes delivered in order, no sample lost or duplicated.
REQ-035 LINE_START pulsed during CAPTURE -> ignored; only one line emitted.
REQ-036 nCLR=0 after 2 samples pushed -> next cycle OUT_VALID=0, nEN=1, LINE_CNT=0; new LINE_START emits header 00.
REQ-037 Checksum on, LINE_LEN=4, D=FE,FF,00,01 -> trailer byte 00; checksum off -> no trailer.
REQ-038 256 back-to-back lines -> header byte sequence 00..FF, LINE_CNT wraps to 00.

Source files
------------

// File: rtl/scan_line_packer.sv
// Scan-line packer: frames each requested line as SYNC_BYTE, line-count header and
// LINE_LEN source samples into a first-word-fall-through byte FIFO.
// Optional macro SCAN_LINE_PACKER_CHECKSUM_EN appends an 8-bit sum trailer per line.
module scan_line_packer #(
  parameter int         LINE_LEN  = 64,
  parameter int         DEPTH     = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic       CLK,
  input  logic       nCLR,
  input  logic       LINE_START,
  input  logic [7:0] D,
  output logic       nEN,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       BUSY,
  output logic [7:0] LINE_CNT
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0] OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [7:0]  LAST_IDX = 8'(LINE_LEN - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_HDR     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
`ifdef SCAN_LINE_PACKER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM    = 3'd4;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] smp);
    return acc + smp;
  endfunction
`endif

  logic [2:0]    state_q, state_d;
  logic [AW:0]   occ_q, occ_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    samp_q, samp_d;
  logic [7:0]    line_cnt_q, line_cnt_d;
  logic [7:0]    mem_q [DEPTH];
`ifdef SCAN_LINE_PACKER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  logic       full;
  logic       pop;
  logic       push;
  logic       src_take;
  logic [7:0] push_byte;

  // Fullness is judged on the registered occupancy, so a same-cycle pop never frees a slot.
  always_comb begin
    full       = (occ_q == FULL_OCC);
    pop        = (occ_q != '0) && OUT_READY;
    push       = 1'b0;
    push_byte  = 8'h00;
    src_take   = 1'b0;
    state_d    = state_q;
    samp_d     = samp_q;
    line_cnt_d = line_cnt_q;
`ifdef SCAN_LINE_PACKER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (LINE_START) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (!full) begin
          push      = 1'b1;
          push_byte = SYNC_BYTE;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (!full) begin
          push      = 1'b1;
          push_byte = line_cnt_q;
          state_d   = S_CAPTURE;
`ifdef SCAN_LINE_PACKER_CHECKSUM_EN
          sum_d     = 8'h00;
`endif
        end
      end
      S_CAPTURE: begin
        if (!full) begin
          push      = 1'b1;
          push_byte = D;
          src_take  = 1'b1;
`ifdef SCAN_LINE_PACKER_CHECKSUM_EN
          sum_d     = csum_add(sum_q, D);
`endif
          if (samp_q == LAST_IDX) begin
            samp_d     = 8'h00;
`ifdef SCAN_LINE_PACKER_CHECKSUM_EN
            state_d    = S_CSUM;
`else
            state_d    = S_IDLE;
            line_cnt_d = line_cnt_q + 8'd1;
`endif
          end else begin
            samp_d = samp_q + 8'd1;
          end
        end
      end
`ifdef SCAN_LINE_PACKER_CHECKSUM_EN
      S_CSUM: begin
        if (!full) begin
          push       = 1'b1;
          push_byte  = sum_q;
          state_d    = S_IDLE;
          line_cnt_d = line_cnt_q + 8'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  always_ff @(posedge CLK) begin
    if (!nCLR) begin
      state_q    <= S_IDLE;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      samp_q     <= 8'h00;
      line_cnt_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      samp_q     <= samp_d;
      line_cnt_q <= line_cnt_d;
    end
  end

  // Storage and running sum carry no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_byte;
`ifdef SCAN_LINE_PACKER_CHECKSUM_EN
    sum_q <= sum_d;
`endif
  end

  assign nEN       = !(src_take && nCLR);
  assign OUT_VALID = nCLR && (occ_q != '0);
  assign OUT_DATA  = OUT_VALID ? mem_q[rd_ptr_q] : 8'h00;
  assign BUSY      = nCLR && (state_q != S_IDLE);
  assign LINE_CNT  = line_cnt_q;

endmodule

// File: tb/tb_scan_line_packer.sv
// Directed bench for scan_line_packer (LINE_LEN=4, DEPTH=4); expected trailer bytes
// follow the SCAN_LINE_PACKER_CHECKSUM_EN macro when it is defined.
module tb_scan_line_packer;
  localparam int LL = 4;
`ifdef SCAN_LINE_PACKER_CHECKSUM_EN
  localparam int NB = LL + 3;
`else
  localparam int NB = LL + 2;
`endif

  logic       CLK = 1'b0;
  logic       nCLR;
  logic       LINE_START;
  logic [7:0] D;
  logic       nEN;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       BUSY;
  logic [7:0] LINE_CNT;

  always #5 CLK = ~CLK;

  scan_line_packer #(.LINE_LEN(LL), .DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK), .nCLR(nCLR), .LINE_START(LINE_START), .D(D), .nEN(nEN),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .BUSY(BUSY), .LINE_CNT(LINE_CNT)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Upstream 8-bit counter: advances only when the packer consumes it.
  logic       d_load = 1'b0;
  logic [7:0] d_val  = 8'h00;
  logic [7:0] d_cnt  = 8'h00;
  assign D = d_cnt;
  always @(posedge CLK) begin
    if (d_load) d_cnt <= d_val;
    else if (!nEN) d_cnt <= d_cnt + 8'd1;
  end

  logic [7:0] got [0:4095];
  int wr_i    = 0;
  int rd_i    = 0;
  int nen_cnt = 0;
  always @(negedge CLK) begin
    if (OUT_VALID && OUT_READY) begin
      got[wr_i] = OUT_DATA;
      wr_i = wr_i + 1;
    end
    if (!nEN) nen_cnt = nen_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic load_d(input logic [7:0] v);
    d_load = 1'b1;
    d_val  = v;
    tick(1);
    d_load = 1'b0;
  endtask

  task automatic start_line();
    LINE_START = 1'b1;
    tick(1);
    LINE_START = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int t;
    t = 0;
    while ((wr_i - rd_i) < n && t < 400) begin
      @(negedge CLK);
      t++;
    end
    chk({tag, "_avail"}, 32'((wr_i - rd_i) >= n), 32'd1);
  endtask

  task automatic exp_byte(input string tag, input logic [7:0] e);
    chk(tag, 32'(got[rd_i]), 32'(e));
    rd_i++;
  endtask

  task automatic expect_line(input string tag, input logic [7:0] hdr, input logic [7:0] s0);
    logic [7:0] v;
    logic [7:0] sum;
    sum = 8'h00;
    exp_byte({tag, "_sync"}, 8'hA5);
    exp_byte({tag, "_hdr"}, hdr);
    for (int k = 0; k < LL; k++) begin
      v   = s0 + 8'(k);
      sum = sum + v;
      exp_byte($sformatf("%s_s%0d", tag, k), v);
    end
`ifdef SCAN_LINE_PACKER_CHECKSUM_EN
    exp_byte({tag, "_csum"}, sum);
`endif
  endtask

  int base;
  int t;

  initial begin
    nCLR = 1'b0; LINE_START = 1'b0; OUT_READY = 1'b1;
    tick(2);
    chk("rst_nEN", 32'(nEN), 32'd1);
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_data", 32'(OUT_DATA), 32'h00);
    chk("rst_linecnt", 32'(LINE_CNT), 32'h00);
    nCLR = 1'b1;

    // Basic line, with a stray LINE_START pulse while capturing
    load_d(8'h00);
    base = nen_cnt;
    start_line();
    tick(3);
    chk("l1_busy_capture", 32'(BUSY), 32'd1);
    start_line();
    wait_bytes("l1", NB);
    tick(10);
    expect_line("l1", 8'h00, 8'h00);
    chk("l1_linecnt", 32'(LINE_CNT), 32'd1);
    chk("l1_nen_cycles", 32'(nen_cnt - base), 32'd4);
    chk("l1_no_extra_line", 32'(wr_i - rd_i), 32'd0);
    chk("l1_idle", 32'(BUSY), 32'd0);

    // Backpressure: FIFO fills, source stalls, head byte holds
    OUT_READY = 1'b0;
    load_d(8'h10);
    base = nen_cnt;
    start_line();
    tick(10);
    chk("bp_valid", 32'(OUT_VALID), 32'd1);
    chk("bp_head", 32'(OUT_DATA), 32'hA5);
    chk("bp_busy", 32'(BUSY), 32'd1);
    chk("bp_nEN", 32'(nEN), 32'd1);
    chk("bp_taken", 32'(nen_cnt - base), 32'd2);
    tick(5);
    chk("bp_head_stable", 32'(OUT_DATA), 32'hA5);
    chk("bp_taken_stable", 32'(nen_cnt - base), 32'd2);
    OUT_READY = 1'b1;
    wait_bytes("bp", NB);
    tick(3);
    expect_line("bp", 8'h01, 8'h10);
    chk("bp_linecnt", 32'(LINE_CNT), 32'd2);
    chk("bp_nen_cycles", 32'(nen_cnt - base), 32'd4);

    // Reset mid-line discards the partial line
    OUT_READY = 1'b0;
    load_d(8'h20);
    base = nen_cnt;
    start_line();
    t = 0;
    while ((nen_cnt - base) < 2 && t < 100) begin tick(1); t++; end
    tick(2);
    chk("mid_two_taken", 32'(nen_cnt - base), 32'd2);
    nCLR = 1'b0;
    #1;
    chk("mid_rst_nEN", 32'(nEN), 32'd1);
    chk("mid_rst_valid", 32'(OUT_VALID), 32'd0);
    tick(1);
    nCLR = 1'b1;
    #1;
    chk("mid_post_valid", 32'(OUT_VALID), 32'd0);
    chk("mid_post_nEN", 32'(nEN), 32'd1);
    chk("mid_post_linecnt", 32'(LINE_CNT), 32'd0);
    chk("mid_post_busy", 32'(BUSY), 32'd0);
    OUT_READY = 1'b1;
    tick(3);
    chk("mid_nothing_out", 32'(wr_i - rd_i), 32'd0);
    load_d(8'h30);
    start_line();
    wait_bytes("mid", NB);
    tick(3);
    expect_line("mid", 8'h00, 8'h30);
    chk("mid_linecnt", 32'(LINE_CNT), 32'd1);

    // Samples straddling the 8-bit wrap
    load_d(8'hFE);
    start_line();
    wait_bytes("wrap", NB);
    tick(3);
    expect_line("wrap", 8'h01, 8'hFE);
    chk("wrap_linecnt", 32'(LINE_CNT), 32'd2);

    // 256 lines back to back: headers 00..FF, counter wraps
    nCLR = 1'b0;
    tick(1);
    nCLR = 1'b1;
    for (int i = 0; i < 256; i++) begin
      start_line();
      wait_bytes($sformatf("run%0d", i), NB);
      chk($sformatf("run%0d_hdr", i), 32'(got[rd_i + 1]), 32'(i[7:0]));
      rd_i = rd_i + NB;
    end
    tick(3);
    chk("run_linecnt_wrap", 32'(LINE_CNT), 32'h00);
    chk("run_idle", 32'(BUSY), 32'd0);
    chk("run_no_extra", 32'(wr_i - rd_i), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
